fib_arbiter: RTL and testbench
==============================

# fib_arbiter

Round-robin arbiter that shares one `fibo` Fibonacci unit between `N` requesters. Each requester presents an index and a level request. The arbiter grants one requester at a time, sequences the unit's `start`/`ready`/`done_tick` handshake, and returns the 20-bit result with a per-requester completion pulse. Out-of-range indices are rejected without occupying the unit.

## Interface
- `N`, default 2: number of requesters, legal range 2..4.
- `clk`  in  1: system clock, rising edge.
- `rst_n`  in  1: reset, asynchronous, active-low. The arbiter drives the internal `fibo` reset with `~rst_n`.
- `req`  in  N: per-requester request level.
- `idx`  in  5*N: packed indices; requester k uses bits [5k+4:5k].
- `gnt`  out  N: one-hot, one-cycle pulse when a request is accepted.
- `done`  out  N: one-hot, one-cycle pulse when that requester's result is valid.
- `result`  out  20: result of the last completed job; held until the next completion.
- `err`  out  1: high together with `done` when the job's index exceeded 30.
- `busy`  out  1: high in every state except IDLE.

## Operation
- States: IDLE, GRANT, WAIT, DONE.
- **IDLE**
  - Requests are sampled only in this state, and only while `fibo.ready = 1`.
  - Winner is the first set `req[k]`, searching from `last+1` modulo N.
  - On a winner: latch `owner = k` and `idx_q = idx[k]`, set `last = k`, go to GRANT.
- **GRANT** (exactly 1 cycle)
  - `gnt[owner] = 1`.
  - If `idx_q <= 30`: `fibo.start = 1` with `fibo.i = idx_q`, then go to WAIT.
  - If `idx_q > 30`: `fibo.start` stays 0, `err_q` is set, and the state goes straight to DONE.
- **WAIT**
  - Holds until `fibo.done_tick` is sampled high.
  - On that edge, `result <= fibo.f` and the state goes to DONE.
- **DONE** (exactly 1 cycle)
  - `done[owner] = 1` and `err = err_q`.
  - If `err_q` was set, `result` is 0 for this completion.
  - `err_q` clears and the state returns to IDLE.
- **Outputs:** `gnt`, `done`, `err` and `busy` are Moore outputs decoded from the registered state. `result` is a register.
- **Requester rule:** a requester drops `req` in the cycle it sees `gnt`. If `req` is still high at the next IDLE it counts as a new request. Dropping `req` before `gnt` withdraws the request.
- **Width rules:**
  - Index 30 gives 832040, the largest value that fits in 20 bits, so 30 is the highest accepted index.
  - Index 0 gives 0 and index 1 gives 1.
- **Fairness:** with all requesters held high, grants rotate 0, 1, …, N-1, 0.

## Timing
- Reset values:
  - state IDLE
  - `gnt = 0`, `done = 0`, `err = 0`, `busy = 0`, `result = 0`
  - `last = N-1`, so requester 0 has first priority after reset.
- Request sampled at edge t (in IDLE): `gnt` and `fibo.start` are high in cycle t+1.
- `done_tick` sampled at edge u (in WAIT): `done` and the valid `result` appear in cycle u+1.
- Error path: `gnt` in cycle t+1, `done` with `err` in cycle t+2.
- Minimum spacing between consecutive grants is 1 IDLE cycle after DONE.
- Reset asserted mid-operation (any state):
  - All outputs go to reset values immediately, with no clock edge needed.
  - `fibo` is reset at the same time.
  - No `done` is issued for the aborted job.
- `idx` changes after `gnt` are ignored, because the index was latched in IDLE.
- Simultaneous requests are resolved only by the round-robin pointer. There is no fixed priority apart from the reset value of `last`.

## Structure
- Package `fib_pkg` holds:
  - constants `IDX_W = 5`, `RES_W = 20`, `IDX_MAX = 30`
  - state enum `arb_state_t` (IDLE, GRANT, WAIT, DONE)
  - function `rr_pick(req, last)`, which returns `{found, index}`.
- The only sub-module is one instance of the existing `fibo` unit. The arbiter owns the `fibo` `start` and `i` inputs exclusively.

## Test plan
1. **Reset:** hold `rst_n = 0` for 2 cycles with `req = 2'b11` → all outputs 0 and no `gnt` during reset. After release, `gnt[0]` is issued first.
2. **Single request:** `req[0]` with `idx[0] = 6` → one-cycle `gnt = 2'b01`, later `done = 2'b01`, `result = 8`, `err = 0`.
3. **Contention:** `req = 2'b11`, `idx[0] = 10`, `idx[1] = 7`, both re-raised after each grant → `done` order is 0 (result 55), 1 (result 13), 0 (result 55), 1 (result 13).
4. **Range limits:** indices 0, 1 and 30 → `result` 0, 1 and 832040 respectively, with `err = 0`.
5. **Error path:** `idx[1] = 31` → `gnt[1]` at t+1, then `done[1]` with `err = 1` and `result = 0` at t+2. `fibo.start` is never asserted.
6. **Reset mid-job:** pull `rst_n` low during WAIT → outputs clear asynchronously and no `done` is issued. A following request with `idx = 6` returns 8.

Source files
------------

// File: rtl/fib_pkg.sv
// Shared constants, state type and round-robin pick helper for the Fibonacci arbiter.
package fib_pkg;

  localparam int unsigned IDX_W   = 5;
  localparam int unsigned RES_W   = 20;
  localparam int unsigned IDX_MAX = 30;
  localparam int unsigned MAX_N   = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } arb_state_t;

  // Returns {found, index}: first set request searching from last+1 modulo n.
  function automatic logic [2:0] rr_pick(input logic [MAX_N-1:0] req,
                                         input logic [1:0]       last,
                                         input int unsigned      n);
    logic        found;
    logic [1:0]  pick;
    int unsigned k;
    found = 1'b0;
    pick  = 2'd0;
    for (int unsigned off = 1; off <= MAX_N; off++) begin
      k = (32'(last) + off) % n;
      if (off <= n && !found && req[k[1:0]]) begin
        found = 1'b1;
        pick  = k[1:0];
      end
    end
    return {found, pick};
  endfunction

endpackage

// File: rtl/fibo.sv
// Iterative Fibonacci unit with start/ready/done_tick handshake; f holds F(i).
module fibo (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [4:0]  i,
  output logic        ready,
  output logic        done_tick,
  output logic [19:0] f
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_OP   = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [19:0] t0_q, t0_d, t1_q, t1_d;
  logic [4:0]  n_q, n_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      t0_q    <= '0;
      t1_q    <= '0;
      n_q     <= '0;
    end else begin
      state_q <= state_d;
      t0_q    <= t0_d;
      t1_q    <= t1_d;
      n_q     <= n_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    t0_d      = t0_q;
    t1_d      = t1_q;
    n_d       = n_q;
    ready     = 1'b0;
    done_tick = 1'b0;
    case (state_q)
      S_IDLE: begin
        ready = 1'b1;
        if (start) begin
          t0_d    = '0;
          t1_d    = 20'd1;
          n_d     = i;
          state_d = S_OP;
        end
      end
      S_OP: begin
        if (n_q == 5'd0) begin
          t1_d    = '0;
          state_d = S_DONE;
        end else if (n_q == 5'd1) begin
          state_d = S_DONE;
        end else begin
          t1_d = t1_q + t0_q;
          t0_d = t1_q;
          n_d  = n_q - 5'd1;
        end
      end
      S_DONE: begin
        done_tick = 1'b1;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign f = t1_q;

endmodule

// File: rtl/fib_arbiter.sv
// Round-robin arbiter sharing one fibo unit between N requesters; rejects indices above 30.
module fib_arbiter
  import fib_pkg::*;
#(
  parameter int unsigned N = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N-1:0]       req,
  input  logic [IDX_W*N-1:0] idx,
  output logic [N-1:0]       gnt,
  output logic [N-1:0]       done,
  output logic [RES_W-1:0]   result,
  output logic               err,
  output logic               busy
);

  arb_state_t         state_q, state_d;
  logic [1:0]         owner_q, owner_d;
  logic [1:0]         last_q, last_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               err_q, err_d;
  logic [RES_W-1:0]   result_q, result_d;

  logic [MAX_N-1:0]   req_pad;
  logic [2:0]         pick;
  logic               idx_ok;

  logic               fibo_start;
  logic               fibo_ready;
  logic               fibo_done_tick;
  logic [RES_W-1:0]   fibo_f;

  assign req_pad = MAX_N'(req);
  assign pick    = rr_pick(req_pad, last_q, N);
  assign idx_ok  = (idx_q <= IDX_W'(IDX_MAX));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      owner_q  <= '0;
      last_q   <= 2'(N - 1);
      idx_q    <= '0;
      err_q    <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      last_q   <= last_d;
      idx_q    <= idx_d;
      err_q    <= err_d;
      result_q <= result_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    last_d   = last_q;
    idx_d    = idx_q;
    err_d    = err_q;
    result_d = result_q;
    case (state_q)
      IDLE: begin
        if (fibo_ready && pick[2]) begin
          owner_d = pick[1:0];
          last_d  = pick[1:0];
          idx_d   = idx[IDX_W*pick[1:0] +: IDX_W];
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (idx_ok) begin
          state_d = WAIT;
        end else begin
          // Rejected job never touches the unit and reports a zero result.
          err_d    = 1'b1;
          result_d = '0;
          state_d  = DONE;
        end
      end
      WAIT: begin
        if (fibo_done_tick) begin
          result_d = fibo_f;
          state_d  = DONE;
        end
      end
      DONE: begin
        err_d   = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    gnt  = '0;
    done = '0;
    for (int unsigned k = 0; k < N; k++) begin
      gnt[k]  = (state_q == GRANT) && (32'(owner_q) == k);
      done[k] = (state_q == DONE) && (32'(owner_q) == k);
    end
  end

  assign err        = (state_q == DONE) && err_q;
  assign busy       = (state_q != IDLE);
  assign result     = result_q;
  assign fibo_start = (state_q == GRANT) && idx_ok;

  fibo u_fibo (
    .clk       (clk),
    .reset     (~rst_n),
    .start     (fibo_start),
    .i         (idx_q),
    .ready     (fibo_ready),
    .done_tick (fibo_done_tick),
    .f         (fibo_f)
  );

endmodule

// File: tb/tb_fib_arbiter.sv
// Self-checking bench for fib_arbiter: directed scenarios plus randomized jobs vs a behavioural model.
module tb_fib_arbiter;

  localparam int N = 2;

  logic           clk;
  logic           rst_n;
  logic [N-1:0]   req;
  logic [5*N-1:0] idx;
  logic [N-1:0]   gnt;
  logic [N-1:0]   done;
  logic [19:0]    result;
  logic           err;
  logic           busy;

  int total;
  int bad;
  int model_last;

  fib_arbiter #(.N(N)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    (req),
    .idx    (idx),
    .gnt    (gnt),
    .done   (done),
    .result (result),
    .err    (err),
    .busy   (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic longint fib(input int n);
    longint a, b, t;
    a = 0;
    b = 1;
    for (int j = 0; j < n; j++) begin
      t = a + b;
      a = b;
      b = t;
    end
    return a;
  endfunction

  // Winner: first set request searching from last+1 modulo N.
  function automatic int model_pick(input logic [N-1:0] r);
    for (int off = 1; off <= N; off++) begin
      if (r[(model_last + off) % N]) return (model_last + off) % N;
    end
    return -1;
  endfunction

  task automatic set_idx(input int k, input logic [4:0] v);
    idx[5*k +: 5] = v;
  endtask

  task automatic wait_gnt(output logic [N-1:0] g, output bit to);
    to = 1'b1;
    g  = '0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (gnt != '0) begin
        g  = gnt;
        to = 1'b0;
        break;
      end
    end
  endtask

  task automatic wait_done(output logic [N-1:0] d, output logic e, output logic [19:0] r,
                           output bit to);
    to = 1'b1;
    d  = '0;
    e  = 1'b0;
    r  = '0;
    for (int c = 0; c < 80; c++) begin
      @(negedge clk);
      if (done != '0) begin
        d  = done;
        e  = err;
        r  = result;
        to = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset;
    logic [N-1:0] g, d;
    logic         e;
    logic [19:0]  r;
    bit           to;
    rst_n = 1'b0;
    req   = 2'b11;
    set_idx(0, 5'd3);
    set_idx(1, 5'd4);
    repeat (2) begin
      @(negedge clk);
      total++;
      if ({gnt, done, err, busy, result} !== '0) begin
        bad++;
        $display("FAIL reset_outputs: gnt=%b done=%b err=%b busy=%b result=%0d, want all 0",
                 gnt, done, err, busy, result);
      end
    end
    rst_n      = 1'b1;
    model_last = N - 1;
    wait_gnt(g, to);
    total++;
    if (to || g !== 2'b01) begin
      bad++;
      $display("FAIL first_grant: gnt=%b timeout=%0d, want 01", g, to);
    end
    req = '0;
    wait_done(d, e, r, to);
    total++;
    if (to || d !== 2'b01 || e !== 1'b0 || r !== 20'd2) begin
      bad++;
      $display("FAIL reset_first_job: done=%b err=%b result=%0d timeout=%0d, want 01/0/2",
               d, e, r, to);
    end
    model_last = 0;
    @(negedge clk);
  endtask

  task automatic test_error;
    rst_n = 1'b1;
    set_idx(1, 5'd31);
    req = 2'b10;
    @(negedge clk);
    total++;
    if (gnt !== 2'b10 || dut.fibo_start !== 1'b0 || busy !== 1'b1) begin
      bad++;
      $display("FAIL err_grant: gnt=%b start=%b busy=%b, want 10/0/1", gnt, dut.fibo_start, busy);
    end
    req = '0;
    @(negedge clk);
    total++;
    if (done !== 2'b10 || err !== 1'b1 || result !== 20'd0 || dut.fibo_start !== 1'b0) begin
      bad++;
      $display("FAIL err_done: done=%b err=%b result=%0d start=%b, want 10/1/0/0",
               done, err, result, dut.fibo_start);
    end
    @(negedge clk);
    total++;
    if (done !== '0 || err !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL err_clear: done=%b err=%b busy=%b, want 0/0/0", done, err, busy);
    end
    model_last = 1;
  endtask

  task automatic test_contention;
    logic [N-1:0] g, d;
    logic         e;
    logic [19:0]  r;
    bit           to;
    int           w;
    set_idx(0, 5'd10);
    set_idx(1, 5'd7);
    req = 2'b11;
    for (int j = 0; j < 4; j++) begin
      w = model_pick(2'b11);
      wait_gnt(g, to);
      total++;
      if (to || g !== N'(1 << w)) begin
        bad++;
        $display("FAIL cont_grant%0d: gnt=%b timeout=%0d, want requester %0d", j, g, to, w);
      end
      req[w] = 1'b0;
      @(negedge clk);
      req[w] = 1'b1;
      wait_done(d, e, r, to);
      if (j == 3) req = '0;
      total++;
      if (to || d !== N'(1 << w) || e !== 1'b0 || r !== 20'(fib(w == 0 ? 10 : 7))) begin
        bad++;
        $display("FAIL cont_done%0d: done=%b err=%b result=%0d timeout=%0d, want req %0d res %0d",
                 j, d, e, r, to, w, fib(w == 0 ? 10 : 7));
      end
      model_last = w;
    end
    @(negedge clk);
  endtask

  task automatic test_single;
    logic [N-1:0] d;
    logic         e;
    logic [19:0]  r;
    bit           to;
    set_idx(0, 5'd6);
    req = 2'b01;
    @(negedge clk);
    total++;
    if (gnt !== 2'b01 || dut.fibo_start !== 1'b1) begin
      bad++;
      $display("FAIL single_grant: gnt=%b start=%b, want 01/1", gnt, dut.fibo_start);
    end
    req = '0;
    set_idx(0, 5'd20);
    @(negedge clk);
    total++;
    if (gnt !== 2'b00 || busy !== 1'b1) begin
      bad++;
      $display("FAIL single_gnt_pulse: gnt=%b busy=%b, want 00/1", gnt, busy);
    end
    wait_done(d, e, r, to);
    total++;
    if (to || d !== 2'b01 || e !== 1'b0 || r !== 20'd8) begin
      bad++;
      $display("FAIL single_done: done=%b err=%b result=%0d timeout=%0d, want 01/0/8",
               d, e, r, to);
    end
    model_last = 0;
    @(negedge clk);
  endtask

  task automatic test_range;
    logic [4:0]   vals [3] = '{5'd0, 5'd1, 5'd30};
    logic [19:0]  exps [3] = '{20'd0, 20'd1, 20'd832040};
    logic [N-1:0] d;
    logic         e;
    logic [19:0]  r;
    bit           to;
    for (int j = 0; j < 3; j++) begin
      set_idx(1, vals[j]);
      req = 2'b10;
      @(negedge clk);
      total++;
      if (gnt !== 2'b10) begin
        bad++;
        $display("FAIL range_grant%0d: gnt=%b, want 10", j, gnt);
      end
      req = '0;
      wait_done(d, e, r, to);
      total++;
      if (to || d !== 2'b10 || e !== 1'b0 || r !== exps[j]) begin
        bad++;
        $display("FAIL range_idx%0d: done=%b err=%b result=%0d timeout=%0d, want 10/0/%0d",
                 vals[j], d, e, r, to, exps[j]);
      end
      model_last = 1;
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid_job;
    logic [N-1:0] d;
    logic         e;
    logic [19:0]  r;
    bit           to;
    int           spurious;
    set_idx(0, 5'd25);
    req = 2'b01;
    @(negedge clk);
    total++;
    if (gnt !== 2'b01) begin
      bad++;
      $display("FAIL mid_grant: gnt=%b, want 01", gnt);
    end
    req = '0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({gnt, done, err, busy, result} !== '0) begin
      bad++;
      $display("FAIL mid_async_clear: gnt=%b done=%b err=%b busy=%b result=%0d, want all 0",
               gnt, done, err, busy, result);
    end
    spurious = 0;
    repeat (3) begin
      @(negedge clk);
      if (done != '0) spurious++;
    end
    rst_n      = 1'b1;
    model_last = N - 1;
    repeat (5) begin
      @(negedge clk);
      if (done != '0 || busy != 1'b0) spurious++;
    end
    total++;
    if (spurious != 0) begin
      bad++;
      $display("FAIL mid_no_done: %0d cycles with done/busy, want 0", spurious);
    end
    set_idx(1, 5'd6);
    req = 2'b10;
    @(negedge clk);
    total++;
    if (gnt !== 2'b10) begin
      bad++;
      $display("FAIL mid_regrant: gnt=%b, want 10", gnt);
    end
    req = '0;
    wait_done(d, e, r, to);
    total++;
    if (to || d !== 2'b10 || e !== 1'b0 || r !== 20'd8) begin
      bad++;
      $display("FAIL mid_after: done=%b err=%b result=%0d timeout=%0d, want 10/0/8",
               d, e, r, to);
    end
    model_last = 1;
    @(negedge clk);
  endtask

  task automatic test_random;
    logic [N-1:0] rq, d;
    logic [4:0]   iv [N];
    logic         e;
    logic [19:0]  r;
    bit           to;
    int           w;
    logic         exp_err;
    logic [19:0]  exp_res;
    for (int j = 0; j < 24; j++) begin
      rq = N'($urandom_range(1, (1 << N) - 1));
      for (int k = 0; k < N; k++) begin
        iv[k] = 5'($urandom_range(0, 31));
        set_idx(k, iv[k]);
      end
      w       = model_pick(rq);
      exp_err = (iv[w] > 5'd30);
      exp_res = exp_err ? 20'd0 : 20'(fib(int'(iv[w])));
      req = rq;
      @(negedge clk);
      total++;
      if (gnt !== N'(1 << w)) begin
        bad++;
        $display("FAIL rand_grant%0d: req=%b gnt=%b, want requester %0d", j, rq, gnt, w);
      end
      req = '0;
      idx = 10'($urandom);
      wait_done(d, e, r, to);
      total++;
      if (to || d !== N'(1 << w) || e !== exp_err || r !== exp_res) begin
        bad++;
        $display("FAIL rand_done%0d: done=%b err=%b result=%0d timeout=%0d, want req %0d %b %0d",
                 j, d, e, r, to, w, exp_err, exp_res);
      end
      model_last = w;
      @(negedge clk);
    end
  endtask

  initial begin
    total      = 0;
    bad        = 0;
    model_last = N - 1;
    rst_n      = 1'b0;
    req        = '0;
    idx        = '0;
    test_reset();
    test_error();
    test_contention();
    test_single();
    test_range();
    test_reset_mid_job();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
